// File: rtl/instr_encoder_loader.sv
// Instruction encoder and instruction-memory loader.
// Packs decoded fields into 32-bit MIPS words and writes them to consecutive
// word addresses. There is a single output write register, and it is held
// until the memory accepts it.
//
// state | meaning
// IDLE  | not loading; a pending write may still drain
// LOAD  | accepting field bundles
// FULL  | DEPTH words written; input blocked until start or finish
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL_ST} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              retire, xfer, legal;
    logic [31:0]       enc_word;

    // The pending write counts against capacity so that a full memory can
    // never have one more word queued behind it.
    always_comb begin
        in_ready = (state_q == LOAD) && (!wr_en || mem_ready) &&
                   ((count + {{ADDR_W{1'b0}}, wr_en}) < DEPTH_C);
    end

    assign retire = wr_en && mem_ready;
    assign xfer   = in_valid && in_ready;
    assign full   = (count == DEPTH_C);
    assign busy   = (state_q == LOAD);

    // The pointer saturates at the last word. A word accepted in the same
    // cycle as a retire goes to the address after the retiring one.
    always_comb begin
        ptr_d = ptr_q;
        if (retire && (ptr_q != LAST_PTR)) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Format-class encoding; unknown opcodes are flagged as illegal.
    always_comb begin
        legal    = 1'b1;
        enc_word = {opcode, 26'd0};
        case (opcode)
            6'b000000: enc_word = {opcode, rs, rt, rd, 5'd0, funct};
            6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000111,
            6'b001000, 6'b001001, 6'b010000, 6'b010001, 6'b100011,
            6'b100111: enc_word = {opcode, rs, rt, imm};
            6'b100000: enc_word = {opcode, rs, rt, 16'd0};
            6'b111000, 6'b111001: enc_word = {opcode, target};
            default:   legal = 1'b0;
        endcase
    end

    // Next-state logic. start takes priority over finish.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (finish) begin
                        state_d = IDLE;
                    end else if (retire && (count == DEPTH_C - 1'b1)) begin
                        state_d = FULL_ST;
                    end
                end
                FULL_ST: if (finish) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write register, counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            count   <= '0;
            ptr_q   <= '0;
            err     <= 1'b0;
        end else if (start) begin
            wr_en <= 1'b0;
            count <= '0;
            ptr_q <= '0;
            err   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (retire) begin
                count <= count + 1'b1;
                wr_en <= 1'b0;
            end
            if (xfer) begin
                if (legal) begin
                    wr_en   <= 1'b1;
                    wr_addr <= ptr_d;
                    wr_data <= enc_word;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios with literal
// expectations, followed by randomized traffic checked against a reference
// model every cycle.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n, start, finish, in_valid, mem_ready;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              in_ready, wr_en, full, err, busy;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;

    int tests = 0;
    int fails = 0;

    // model state: mode 0=idle 1=load 2=full
    int m_mode, m_count, m_ptr, m_pend, m_addr, m_err;
    int unsigned m_data;

    int legal_ops[$] = '{0, 2, 3, 4, 5, 7, 8, 9, 16, 17, 35, 39, 32, 56, 57};

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_ready(mem_ready), .count(count), .full(full), .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(input int op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int unsigned encode(input int op, input int a, input int b,
                                           input int c, input int f, input int im,
                                           input int tg);
        int unsigned w;
        w = op * (1 << 26);
        if (op == 0)            w += a * (1 << 21) + b * (1 << 16) + c * (1 << 11) + f;
        else if (op == 32)      w += a * (1 << 21) + b * (1 << 16);
        else if (op >= 56)      w += tg;
        else                    w += a * (1 << 21) + b * (1 << 16) + im;
        return w;
    endfunction

    function automatic bit model_ready();
        return (m_mode == 1) && (m_pend == 0 || mem_ready) && (m_count + m_pend < DEPTH);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, model_ready());
        chk("wr_en", wr_en, m_pend);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("count", count, m_count);
        chk("full", full, m_count == DEPTH);
        chk("err", err, m_err);
        chk("busy", busy, m_mode == 1);
    endtask

    task automatic model_update();
        bit rdy, retire, xfer;
        rdy = model_ready();
        if (!rst_n) begin
            m_mode = 0; m_count = 0; m_ptr = 0; m_pend = 0;
            m_addr = 0; m_data = 0; m_err = 0;
        end else if (start) begin
            m_mode = 1; m_count = 0; m_ptr = 0; m_pend = 0; m_err = 0;
        end else begin
            retire = (m_pend != 0) && mem_ready;
            xfer   = in_valid && rdy;
            if (retire) begin
                m_count++;
                m_pend = 0;
                if (m_ptr < DEPTH - 1) m_ptr++;
            end
            if (xfer) begin
                if (is_legal(opcode)) begin
                    m_pend = 1;
                    m_addr = m_ptr;
                    m_data = encode(opcode, rs, rt, rd, funct, imm, target);
                end else begin
                    m_err = 1;
                end
            end
            if (m_mode == 1) begin
                if (finish) m_mode = 0;
                else if (retire && m_count == DEPTH) m_mode = 2;
            end else if (m_mode == 2 && finish) begin
                m_mode = 0;
            end
        end
    endtask

    // One clock: compare outputs before the edge, advance the model at it.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic fields(input int op, input int a, input int b, input int c,
                          input int f, input int im, input int tg);
        opcode = 6'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c);
        funct = 6'(f); imm = 16'(im); target = 26'(tg);
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        fields(0, 0, 0, 0, 0, 0, 0);
        m_mode = 0; m_count = 0; m_ptr = 0; m_pend = 0; m_addr = 0; m_data = 0; m_err = 0;
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("reset wr_en", wr_en, 0);
        chk("reset count", count, 0);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 0);

        // first I-type write
        do_start();
        fields(2, 1, 2, 0, 0, 5, 0); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("itype wr_en", wr_en, 1);
        chk("itype wr_addr", wr_addr, 0);
        chk("itype wr_data", wr_data, 32'h08220005);
        step();
        chk("itype count", count, 1);

        // back-to-back R-type then J-type
        do_start();
        fields(0, 3, 4, 5, 32, 0, 0); in_valid = 1'b1; step();
        chk("rtype wr_data", wr_data, 32'h00642820);
        chk("rtype wr_addr", wr_addr, 0);
        #1 chk("b2b in_ready", in_ready, 1);
        fields(56, 0, 0, 0, 0, 0, 32'h100); step(); in_valid = 1'b0;
        chk("jtype wr_data", wr_data, 32'hE0000100);
        chk("jtype wr_addr", wr_addr, 1);
        step();

        // memory back-pressure
        fields(9, 7, 8, 0, 0, 16'h1234, 0); in_valid = 1'b1; step();
        mem_ready = 1'b0; fields(35, 1, 1, 0, 0, 1, 0);
        repeat (3) step();
        chk("stall wr_data", wr_data, 32'h24E81234);
        chk("stall wr_addr", wr_addr, 2);
        chk("stall count", count, 2);
        in_valid = 1'b0; mem_ready = 1'b1; step();
        chk("stall retire count", count, 3);

        // illegal opcode
        fields(63, 0, 0, 0, 0, 0, 0); in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("illegal err", err, 1);
        chk("illegal wr_en", wr_en, 0);
        chk("illegal count", count, 3);
        do_start();
        chk("start clears err", err, 0);

        // fill to DEPTH
        fields(8, 2, 3, 0, 0, 16'hFFFF, 0); in_valid = 1'b1;
        repeat (6) step();
        in_valid = 1'b0;
        #1;
        chk("fill full", full, 1);
        chk("fill count", count, DEPTH);
        chk("fill in_ready", in_ready, 0);
        do_start();
        chk("restart count", count, 0);
        chk("restart busy", busy, 1);

        // reset while a write is stalled
        mem_ready = 1'b0; in_valid = 1'b1; fields(57, 0, 0, 0, 0, 0, 26'h3FFFFFF); step();
        in_valid = 1'b0;
        chk("pending wr_en", wr_en, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("rst drop wr_en", wr_en, 0);
        chk("rst busy", busy, 0);
        #1 chk("rst in_ready", in_ready, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 29) == 0);
            finish    = ($urandom_range(0, 39) == 0);
            in_valid  = $urandom_range(0, 1);
            mem_ready = ($urandom_range(0, 3) != 0);
            fields(($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, legal_ops.size() - 1)]
                                               : $urandom_range(0, 63),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 63), $urandom_range(0, 65535),
                   $urandom_range(0, 26'h3FFFFFF));
            step();
        end
        rst_n = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
